// File: rtl/lenet_pkg.sv
// Shared constants, state encoding and helpers for the LeNet layer sequencer.
package lenet_pkg;

   localparam int unsigned N_LAYERS_DEF  = 6;
   localparam int unsigned TO_CYCLES_DEF = 1048575;
   localparam int unsigned IDX_W         = 3;
   localparam int unsigned TC_W          = 32;
   localparam int unsigned WD_W          = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_ERR  = 2'd3
   } sched_state_e;

   // Saturating increment for the cycle counter.
   function automatic logic [TC_W-1:0] sat_inc(input logic [TC_W-1:0] v);
      return (v == '1) ? v : v + TC_W'(1);
   endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Control/status bundle between the inference host and the layer sequencer.
interface layer_sched_if #(
   parameter int unsigned N_LAYERS = lenet_pkg::N_LAYERS_DEF
);
   import lenet_pkg::*;

   logic                start;
   logic                abort;
   logic [N_LAYERS-1:0] layer_finish;
   logic [N_LAYERS-1:0] layer_en;
   logic [IDX_W-1:0]    layer_idx;
   logic                busy;
   logic                done;
   logic                err;
   logic [TC_W-1:0]     total_cycles;

   modport master (
      output start, abort, layer_finish,
      input  layer_en, layer_idx, busy, done, err, total_cycles
   );

   modport slave (
      input  start, abort, layer_finish,
      output layer_en, layer_idx, busy, done, err, total_cycles
   );

endinterface

// File: rtl/layer_watchdog.sv
// Per-layer watchdog: counts enabled cycles, flags expiry at TO_CYCLES-1.
module layer_watchdog
   import lenet_pkg::*;
#(
   parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic cnt_en_i,
   output logic expire_c
);

   logic [WD_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (cnt_en_i) begin
         count_d = count_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_c = cnt_en_i && !clr_i && (count_q == WD_W'(TO_CYCLES - 32'd1));

endmodule

// File: rtl/layer_sched.sv
// Sequences the network layers one at a time with a one-cycle enable gap,
// a per-layer watchdog, abort and a saturating run-length counter.
module layer_sched
   import lenet_pkg::*;
#(
   parameter int unsigned N_LAYERS  = N_LAYERS_DEF,
   parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic          clk,
   input  logic          rst,
   layer_sched_if.slave  bus
);

   localparam logic [N_LAYERS-1:0] EN_ONE   = N_LAYERS'(1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_LAYERS - 1);

   sched_state_e        state_q, state_d;
   logic [N_LAYERS-1:0] layer_en_q, layer_en_d;
   logic [IDX_W-1:0]    layer_idx_q, layer_idx_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [TC_W-1:0]     total_q, total_d;

   logic                finish_cur_c;
   logic                wd_clr_c;
   logic                wd_en_c;
   logic                wd_expire_c;
   logic [IDX_W-1:0]    idx_nxt_c;

   assign finish_cur_c = bus.layer_finish[layer_idx_q];
   assign idx_nxt_c    = layer_idx_q + IDX_W'(1);

   // Watchdog only runs in RUN; any other state holds it cleared so each entry starts at zero.
   assign wd_clr_c = (state_q != ST_RUN);
   assign wd_en_c  = (state_q == ST_RUN);

   layer_watchdog #(
      .TO_CYCLES (TO_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (wd_clr_c),
      .cnt_en_i (wd_en_c),
      .expire_c (wd_expire_c)
   );

   always_comb begin
      state_d     = state_q;
      layer_en_d  = layer_en_q;
      layer_idx_d = layer_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      total_d     = total_q;

      if (state_q == ST_RUN || state_q == ST_GAP) begin
         total_d = sat_inc(total_q);
      end

      unique case (state_q)
         ST_IDLE, ST_ERR: begin
            if (bus.start) begin
               state_d     = ST_RUN;
               layer_idx_d = '0;
               layer_en_d  = EN_ONE;
               busy_d      = 1'b1;
               err_d       = 1'b0;
               total_d     = '0;
            end
         end
         ST_RUN: begin
            // Priority: abort, then finish of the current layer, then watchdog.
            if (bus.abort) begin
               state_d    = ST_IDLE;
               layer_en_d = '0;
               busy_d     = 1'b0;
            end else if (finish_cur_c) begin
               layer_en_d = '0;
               if (layer_idx_q == IDX_LAST) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_GAP;
               end
            end else if (wd_expire_c) begin
               state_d    = ST_ERR;
               layer_en_d = '0;
               busy_d     = 1'b0;
               err_d      = 1'b1;
            end
         end
         ST_GAP: begin
            if (bus.abort) begin
               state_d    = ST_IDLE;
               layer_en_d = '0;
               busy_d     = 1'b0;
            end else begin
               state_d     = ST_RUN;
               layer_idx_d = idx_nxt_c;
               layer_en_d  = EN_ONE << idx_nxt_c;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         layer_en_q  <= '0;
         layer_idx_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         total_q     <= '0;
      end else begin
         state_q     <= state_d;
         layer_en_q  <= layer_en_d;
         layer_idx_q <= layer_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         total_q     <= total_d;
      end
   end

   assign bus.layer_en     = layer_en_q;
   assign bus.layer_idx    = layer_idx_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.total_cycles = total_q;

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: normal run, stray finish, timeout, abort race,
// reset mid-run and start while busy.
`timescale 1ns/1ps
module tb_layer_sched;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   done_cnt = 0;
   int   base;

   layer_sched_if #(.N_LAYERS(6)) bus();

   layer_sched #(
      .N_LAYERS  (6),
      .TO_CYCLES (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [31:0] idx, input logic [31:0] err,
                           input logic [31:0] total);
      chk({tag, "_en"},    32'(bus.layer_en), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy), 32'd0);
      chk({tag, "_done"},  32'(bus.done), 32'd0);
      chk({tag, "_idx"},   32'(bus.layer_idx), idx);
      chk({tag, "_err"},   32'(bus.err), err);
      chk({tag, "_total"}, bus.total_cycles, total);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Entered on the cycle the layer's enable rose; finishes it 10 cycles later.
   task automatic layer_pass(input int l, input logic [5:0] noise_fin, input logic noise_start);
      logic [5:0] exp_en;
      exp_en = 6'd1 << l;
      chk("en_rise", 32'(bus.layer_en), 32'(exp_en));
      chk("idx_run", 32'(bus.layer_idx), 32'(l));
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 3) begin
            bus.layer_finish = noise_fin;
            bus.start        = noise_start;
         end
         if (c == 4) begin
            bus.layer_finish = '0;
            bus.start        = 1'b0;
            chk("en_hold", 32'(bus.layer_en), 32'(exp_en));
         end
      end
      bus.layer_finish = exp_en;
      tick();
      bus.layer_finish = '0;
   endtask

   task automatic gap(input int l);
      chk("gap_en",   32'(bus.layer_en), 32'd0);
      chk("gap_busy", 32'(bus.busy), 32'd1);
      chk("gap_idx",  32'(bus.layer_idx), 32'(l));
      tick();
   endtask

   task automatic run_to_done(input int noise_l, input logic [5:0] noise_fin, input logic noise_start);
      base = done_cnt;
      pulse_start();
      chk("run_busy", 32'(bus.busy), 32'd1);
      chk("run_total0", bus.total_cycles, 32'd0);
      for (int l = 0; l < 6; l++) begin
         if (l == noise_l) layer_pass(l, noise_fin, noise_start);
         else              layer_pass(l, 6'd0, 1'b0);
         if (l < 5) gap(l);
      end
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("done_busy",  32'(bus.busy), 32'd0);
      chk("done_en",    32'(bus.layer_en), 32'd0);
      chk("done_idx",   32'(bus.layer_idx), 32'd5);
      chk("done_total", bus.total_cycles, 32'd71);
      tick();
      chk("done_drop",    32'(bus.done), 32'd0);
      chk("total_frozen", bus.total_cycles, 32'd71);
      chk("done_count",   32'(done_cnt - base), 32'd1);
   endtask

   initial begin
      rst              = 1'b1;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.layer_finish = '0;
      tick();
      tick();
      chk_idle("rst", 32'd0, 32'd0, 32'd0);
      rst = 1'b0;
      tick();
      chk_idle("idle", 32'd0, 32'd0, 32'd0);

      // Normal run with a stray finish[3] while layer 1 is active.
      run_to_done(1, 6'b001000, 1'b0);

      // Start pulsed during layer 1 must be ignored.
      run_to_done(1, 6'd0, 1'b1);

      // Layer 2 never finishes; watchdog trips 16 cycles after its enable rose.
      pulse_start();
      for (int l = 0; l < 2; l++) begin
         layer_pass(l, 6'd0, 1'b0);
         gap(l);
      end
      chk("to_en2", 32'(bus.layer_en), 32'h4);
      repeat (15) tick();
      chk("to_en_late", 32'(bus.layer_en), 32'h4);
      chk("to_err_late", 32'(bus.err), 32'd0);
      tick();
      chk_idle("timeout", 32'd2, 32'd1, 32'd40);
      tick();
      chk("err_sticky", 32'(bus.err), 32'd1);
      chk("err_idx",    32'(bus.layer_idx), 32'd2);
      pulse_start();
      chk("restart_en",    32'(bus.layer_en), 32'h1);
      chk("restart_err",   32'(bus.err), 32'd0);
      chk("restart_idx",   32'(bus.layer_idx), 32'd0);
      chk("restart_total", bus.total_cycles, 32'd0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk_idle("abort_l0", 32'd0, 32'd0, 32'd1);

      // Abort and layer_finish[4] in the same cycle: abort wins.
      base = done_cnt;
      pulse_start();
      for (int l = 0; l < 4; l++) begin
         layer_pass(l, 6'd0, 1'b0);
         gap(l);
      end
      chk("race_en4", 32'(bus.layer_en), 32'h10);
      repeat (10) tick();
      bus.abort        = 1'b1;
      bus.layer_finish = 6'b010000;
      tick();
      bus.abort        = 1'b0;
      bus.layer_finish = '0;
      chk_idle("race", 32'd4, 32'd0, 32'd59);
      tick();
      chk("race_no_done", 32'(done_cnt - base), 32'd0);
      chk("race_idle",    32'(bus.busy), 32'd0);

      // Reset during layer 3, coincident with start; then resume two cycles later.
      pulse_start();
      for (int l = 0; l < 3; l++) begin
         layer_pass(l, 6'd0, 1'b0);
         gap(l);
      end
      chk("rst_en3", 32'(bus.layer_en), 32'h8);
      repeat (5) tick();
      rst       = 1'b1;
      bus.start = 1'b1;
      tick();
      rst       = 1'b0;
      bus.start = 1'b0;
      chk_idle("rst_mid", 32'd0, 32'd0, 32'd0);
      tick();
      run_to_done(-1, 6'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/layer_sched.md
LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 SHALL have parameter N_LAYERS, default 6: number of sequenced layers (conv1, pool1, conv2, pool2, fc_1, fc_2).
REQ-002 SHALL have parameter TO_CYCLES, default 1048575: per-layer watchdog limit in cycles.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: pulse that begins one inference; honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1: stop the sequence immediately.
REQ-007 SHALL have port layer_finish, input, N_LAYERS: per-layer finish pulses.
REQ-008 SHALL have port layer_en, output, N_LAYERS: level enables, one-hot or zero, registered.
REQ-009 SHALL have port layer_idx, output, 3: index of the current or last-issued layer.
REQ-010 SHALL have port busy, output, 1: high in RUN and GAP.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at sequence completion.
REQ-012 SHALL have port err, output, 1: sticky watchdog-timeout flag.
REQ-013 SHALL have port total_cycles, output, 32: cycles from start to done, saturating at 0xFFFFFFFF.

Function
REQ-014 SHALL implement states IDLE, RUN, GAP and ERR.
REQ-015 In IDLE, start SHALL set layer_idx=0, clear err and total_cycles, and enter RUN; layer_en[0] SHALL be high on the cycle after start.
REQ-016 In RUN, layer_en SHALL equal 1<<layer_idx, held level until that layer's finish pulse.
REQ-017 A layer_finish[layer_idx] pulse at cycle t, with layer_idx<N_LAYERS-1, SHALL drop layer_en at t+1 (GAP), increment layer_idx, and raise the next enable at t+2.
- GAP lasts exactly 1 cycle so every layer sees a fresh rising edge on its enable.
REQ-018 A layer_finish[N_LAYERS-1] pulse at cycle t SHALL give layer_en=0, done=1 and busy=0 at t+1, with return to IDLE.
REQ-019 layer_finish bits other than layer_idx, and any finish seen outside RUN, SHALL be ignored.
REQ-020 A watchdog counter SHALL clear on each RUN entry and increment every RUN cycle; on reaching TO_CYCLES-1 without finish, the block SHALL enter ERR with layer_en=0 and err=1.
REQ-021 ERR SHALL hold err and layer_idx until start, which re-runs from layer 0 and clears err.
REQ-022 abort in RUN or GAP SHALL zero layer_en next cycle and enter IDLE with no done pulse; err SHALL be unchanged.
REQ-023 If abort and finish occur in the same cycle, abort SHALL win.
REQ-024 start while busy SHALL be ignored.
REQ-025 total_cycles SHALL increment every busy cycle, freeze at done, ERR or abort, and stay readable until the next accepted start.

Reset
REQ-026 rst SHALL force IDLE and set layer_en=0, layer_idx=0, busy=0, done=0, err=0, total_cycles=0 and watchdog=0 on the next edge.
REQ-027 rst mid-sequence SHALL behave like abort and SHALL also clear err and total_cycles; rst SHALL take priority over start and abort.

Structure
REQ-028 State encodings and the N_LAYERS and TO_CYCLES defaults SHALL live in the shared package lenet_pkg.
REQ-029 The watchdog SHALL be a separate sub-module layer_watchdog (clear, count-enable, expire).
- All other logic stays flat.

Verification
REQ-030 Bench SHALL cover normal run: N_LAYERS=6, each layer finishes 10 cycles after its enable rises -> enables one-hot in order, each with a 1-cycle gap; one done pulse; total_cycles=71.
REQ-031 Bench SHALL cover stray finish: layer_finish[3] pulsed while layer_idx=1 -> ignored, layer_en stays 0b000010.
REQ-032 Bench SHALL cover timeout: TO_CYCLES=16, layer 2 never finishes -> ERR 16 cycles after layer_en[2] rose, err=1, layer_en=0, layer_idx=2; a later start restarts at layer 0 with err=0.
REQ-033 Bench SHALL cover abort racing finish: abort and layer_finish[4] in the same cycle -> IDLE next cycle, no done, layer_idx=4.
REQ-034 Bench SHALL cover reset mid-run: rst during layer 3 -> all outputs 0 next cycle; a start 2 cycles later runs normally.
REQ-035 Bench SHALL cover start while busy: start pulsed during layer 1 -> no restart; the sequence completes with a single done.
